npc_btb: RTL and testbench
==========================

Name: npc_btb

Overview:
- Parametrised successor of the combinational next-PC logic: it now owns the fetch PC register and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Predicts branch/jump targets at IF and handles an optional MIPS delay slot.
- Accepts branch/jump resolution from ID and redirects on misprediction; exception and ERET vectors override everything.
- Sits at the head of the IF stage and feeds the IM address and IF/ID register.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_4180, exception entry address.
- ENTRIES, 16, BTB entries; power of two, 2 to 256.
- TAG_W, 8, tag bits stored per entry.
- DELAY_SLOT, 1, 1 = MIPS delay slot present, 0 = none.
- CNT_W, 16, width of the saturating mispredict counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- stall  input  1  hold PC and pending state (hazard stall).
- exc_req  input  1  take exception: next PC = EXC_VECTOR.
- eret_req  input  1  return: next PC = epc.
- epc  input  32  return address.
- res_valid  input  1  ID resolves a control-transfer instruction this cycle.
- res_pc  input  32  PC of the resolved instruction.
- res_taken  input  1  actual direction.
- res_target  input  32  actual target (branchImm / jumpImm / JumpRegister computed in ID).
- res_pred_taken  input  1  prediction carried with the instruction.
- res_pred_target  input  32  predicted target carried with the instruction.
- pc  output  32  current fetch PC.
- pred_taken  output  1  prediction for the instruction at pc; travels down the pipe.
- pred_target  output  32  predicted target for pc.
- flush  output  1  combinational; squash the wrong-path instruction in IF/ID.
- mispredict_cnt  output  CNT_W  saturating count of mispredicts.

Behaviour:
- Index: idx = pc[log2(ENTRIES)+1:2]. Tag: pc[log2(ENTRIES)+TAG_W+1 : log2(ENTRIES)+2].
- Entry fields: valid, tag, target[31:0], ctr[1:0].
- Lookup (combinational): pred_taken = valid & tag match & ctr[1]; pred_target = entry target, or 0 when pred_taken = 0.
- mispredict = res_valid & (res_taken != res_pred_taken | (res_taken & res_target != res_pred_target)).
- Recovery address: res_taken ? res_target : res_pc + 4 + 4*DELAY_SLOT.

State:
- pc register.
- pending flag plus pend_target[31:0]; used only when DELAY_SLOT = 1. Set when a predicted-taken instruction is fetched: the next cycle fetches the delay slot, the cycle after that fetches pend_target.

Next-PC priority, highest first:
1. reset = 0: pc = RESET_PC; pending = 0; all BTB valid bits = 0; mispredict_cnt = 0. Reset wins over every other input.
2. exc_req: pc = EXC_VECTOR; pending = 0. exc_req wins over eret_req.
3. eret_req: pc = epc; pending = 0.
4. mispredict: pc = recovery address; pending = 0; flush = 1. This applies even when stall = 1, because redirect beats stall.
5. stall: pc and pending hold.
6. pending: pc = pend_target; pending = 0.
7. pred_taken:
   - DELAY_SLOT = 1: pc = pc + 4; pending = 1; pend_target = pred_target.
   - DELAY_SLOT = 0: pc = pred_target.
8. Otherwise pc = pc + 4. 32-bit wrap-around is allowed, with no error.

Flush:
- flush = mispredict & !exc_req & !eret_req.

BTB update:
- Performed on every res_valid clock edge, independent of stall.
- Hit on res_pc (same idx and tag):
  - taken: ctr = min(ctr + 1, 3), target = res_target.
  - not taken: ctr = max(ctr - 1, 0).
- Miss:
  - res_taken: allocate with valid = 1, tag, target = res_target, ctr = 2'b10.
  - not taken: no write.
- Same-cycle lookup and update of one entry: the lookup sees the old contents (write-after-read).

mispredict_cnt:
- Increments on each mispredict and saturates at all-ones.

Latency:
- Prediction is available in the same cycle as pc.
- Recovery takes effect on the next edge, at a cost of 1 bubble (+1 for a not-taken delay-slot case already fetched).

Test Plan:
- Reset: hold reset = 0 for 2 cycles, then release -> pc = 0x3000, then 0x3004, 0x3008; pred_taken = 0; mispredict_cnt = 0.
- Cold taken branch: res_valid, res_pc = 0x3008, res_taken = 1, res_target = 0x3100, res_pred_taken = 0 -> next pc = 0x3100, flush = 1, cnt = 1. Refetching 0x3008 later -> pred_taken = 1, pred_target = 0x3100.
- Delay-slot sequence: with the BTB trained as above and pc = 0x3008 (pred_taken = 1) -> pc sequence 0x300C, then 0x3100. With stall held 2 cycles at 0x300C, pc stays 0x300C and is still followed by 0x3100.
- Not-taken mispredict: res_pc = 0x3008, res_taken = 0, res_pred_taken = 1 -> pc = 0x3010, pending cleared, flush = 1. Entry ctr goes 2 -> 1, so the next lookup has pred_taken = 0.
- Priority: exc_req, eret_req and mispredict asserted in the same cycle -> pc = 0x4180, flush = 0, pending = 0. eret_req alone with epc = 0x3020 -> pc = 0x3020.
- Saturation and aliasing: with CNT_W = 2, 5 mispredicts -> cnt = 3. A branch at 0x3008 + 4*ENTRIES shares the same idx but has a different tag -> miss, pred_taken = 0.

Source files
------------

// File: rtl/npc_btb.sv
// npc_btb: fetch-PC register with a direct-mapped branch target buffer.
//
// Predicts the next fetch address at IF from a BTB holding 2-bit
// saturating direction counters. It handles an optional MIPS delay slot,
// recovers from ID-stage mispredictions, and gives exception/ERET vectors
// the highest priority among the redirect sources.
//
// Ports:
//   clk             rising-edge clock
//   reset           synchronous, active-low reset
//   stall           hold pc and pending delay-slot state
//   exc_req         redirect to EXC_VECTOR
//   eret_req        redirect to epc
//   epc             ERET return address
//   res_valid       ID resolves a control-transfer instruction this cycle
//   res_pc          PC of the resolved instruction
//   res_taken       actual direction
//   res_target      actual target
//   res_pred_taken  prediction that travelled with the instruction
//   res_pred_target predicted target that travelled with the instruction
//   pc              current fetch PC
//   pred_taken      prediction for the instruction at pc
//   pred_target     predicted target for pc (0 when not predicted taken)
//   flush           squash the wrong-path instruction in IF/ID
//   mispredict_cnt  saturating count of mispredicts
module npc_btb #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter int          ENTRIES    = 16,
  parameter int          TAG_W      = 8,
  parameter int          DELAY_SLOT = 1,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [31:0]      epc,
  input  logic             res_valid,
  input  logic [31:0]      res_pc,
  input  logic             res_taken,
  input  logic [31:0]      res_target,
  input  logic             res_pred_taken,
  input  logic [31:0]      res_pred_target,
  output logic [31:0]      pc,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  output logic             flush,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);

  // Offset from a not-taken branch to the first instruction after it
  // (skips the delay slot when one exists).
  localparam logic [31:0] FALL_OFS = (DELAY_SLOT != 0) ? 32'd8 : 32'd4;

  logic [31:0]      pc_reg, pc_next;
  logic             pending_reg, pending_next;
  logic [31:0]      pend_target_reg, pend_target_next;
  logic [CNT_W-1:0] cnt_reg;

  // Valid bits live in flops so reset can clear them in one cycle; the
  // payload arrays need no reset because valid gates every read.
  logic [ENTRIES-1:0] valid_reg;
  logic [TAG_W-1:0]   tag_mem    [ENTRIES];
  logic [31:0]        target_mem [ENTRIES];
  logic [1:0]         ctr_mem    [ENTRIES];

  // Lookup side (fetch PC)
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  // Update side (resolved PC)
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;

  logic             mispredict;
  logic [31:0]      recovery_pc;

  assign lk_idx = pc_reg[IDX_W+1:2];
  assign lk_tag = pc_reg[IDX_W+TAG_W+1:IDX_W+2];
  assign lk_hit = valid_reg[lk_idx] && (tag_mem[lk_idx] == lk_tag);

  assign pred_taken  = lk_hit && ctr_mem[lk_idx][1];
  assign pred_target = pred_taken ? target_mem[lk_idx] : 32'd0;

  assign up_idx = res_pc[IDX_W+1:2];
  assign up_tag = res_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign up_hit = valid_reg[up_idx] && (tag_mem[up_idx] == up_tag);

  assign mispredict = res_valid &&
                      ((res_taken != res_pred_taken) ||
                       (res_taken && (res_target != res_pred_target)));

  assign recovery_pc = res_taken ? res_target : (res_pc + FALL_OFS);

  // A redirect from an exception or ERET already discards the wrong path,
  // so flush is only raised for a plain misprediction.
  assign flush = mispredict && !exc_req && !eret_req;

  assign pc             = pc_reg;
  assign mispredict_cnt = cnt_reg;

  always_comb begin
    pc_next          = pc_reg;
    pending_next     = pending_reg;
    pend_target_next = pend_target_reg;
    if (exc_req) begin
      pc_next      = EXC_VECTOR;
      pending_next = 1'b0;
    end else if (eret_req) begin
      pc_next      = epc;
      pending_next = 1'b0;
    end else if (mispredict) begin
      // Redirect beats stall: the wrong-path fetch must not survive.
      pc_next      = recovery_pc;
      pending_next = 1'b0;
    end else if (stall) begin
      pc_next      = pc_reg;
    end else if (pending_reg) begin
      pc_next      = pend_target_reg;
      pending_next = 1'b0;
    end else if (pred_taken) begin
      if (DELAY_SLOT != 0) begin
        // Fetch the delay slot first, then the predicted target.
        pc_next          = pc_reg + 32'd4;
        pending_next     = 1'b1;
        pend_target_next = pred_target;
      end else begin
        pc_next          = pred_target;
      end
    end else begin
      pc_next      = pc_reg + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_reg          <= RESET_PC;
      pending_reg     <= 1'b0;
      pend_target_reg <= 32'd0;
      cnt_reg         <= '0;
    end else begin
      pc_reg          <= pc_next;
      pending_reg     <= pending_next;
      pend_target_reg <= pend_target_next;
      if (mispredict && (cnt_reg != {CNT_W{1'b1}})) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  // BTB training. The lookup reads the arrays combinationally before this
  // edge, so a same-cycle lookup of the updated entry sees the old contents.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_reg <= '0;
    end else if (res_valid) begin
      if (up_hit) begin
        if (res_taken) begin
          ctr_mem[up_idx]    <= (ctr_mem[up_idx] == 2'b11) ? 2'b11 : ctr_mem[up_idx] + 2'd1;
          target_mem[up_idx] <= res_target;
        end else begin
          ctr_mem[up_idx]    <= (ctr_mem[up_idx] == 2'b00) ? 2'b00 : ctr_mem[up_idx] - 2'd1;
        end
      end else if (res_taken) begin
        valid_reg[up_idx]  <= 1'b1;
        tag_mem[up_idx]    <= up_tag;
        target_mem[up_idx] <= res_target;
        ctr_mem[up_idx]    <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_npc_btb.sv
// tb_npc_btb: directed self-checking bench for npc_btb (ENTRIES=16,
// DELAY_SLOT=1, CNT_W=2). Each step pushes the expected post-edge state to
// a scoreboard queue; after the edge the entry is popped and compared.
module tb_npc_btb;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_taken;
  logic [31:0] res_target;
  logic        res_pred_taken;
  logic [31:0] res_pred_target;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        flush;
  logic [1:0]  mispredict_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptgt;
    logic [1:0]  cnt;
  } exp_t;

  exp_t  sb_q[$];
  string name_q[$];

  npc_btb #(
    .RESET_PC   (32'h0000_3000),
    .EXC_VECTOR (32'h0000_4180),
    .ENTRIES    (16),
    .TAG_W      (8),
    .DELAY_SLOT (1),
    .CNT_W      (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .exc_req         (exc_req),
    .eret_req        (eret_req),
    .epc             (epc),
    .res_valid       (res_valid),
    .res_pc          (res_pc),
    .res_taken       (res_taken),
    .res_target      (res_target),
    .res_pred_taken  (res_pred_taken),
    .res_pred_target (res_pred_target),
    .pc              (pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .flush           (flush),
    .mispredict_cnt  (mispredict_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Check the combinational flush for the inputs currently driven.
  task automatic chk_flush(input string tag, input logic exp);
    #1;
    chk({tag, ".flush"}, {31'd0, flush}, {31'd0, exp});
  endtask

  // Push expected post-edge state, clock once, pop and compare.
  task automatic step(input string name, input logic [31:0] e_pc, input logic e_pt,
                      input logic [31:0] e_ptgt, input logic [1:0] e_cnt);
    exp_t e;
    exp_t got;
    string nm;
    e.pc = e_pc; e.pt = e_pt; e.ptgt = e_ptgt; e.cnt = e_cnt;
    sb_q.push_back(e);
    name_q.push_back(name);
    @(posedge clk);
    #1;
    res_valid = 1'b0;
    exc_req   = 1'b0;
    eret_req  = 1'b0;
    #1;
    got = sb_q.pop_front();
    nm  = name_q.pop_front();
    chk({nm, ".pc"},    pc, got.pc);
    chk({nm, ".pt"},    {31'd0, pred_taken}, {31'd0, got.pt});
    chk({nm, ".ptgt"},  pred_target, got.ptgt);
    chk({nm, ".cnt"},   {30'd0, mispredict_cnt}, {30'd0, got.cnt});
    $display("step %-9s pc=%h pred_taken=%0d pred_target=%h cnt=%0d",
             nm, pc, pred_taken, pred_target, mispredict_cnt);
  endtask

  task automatic resolve(input logic [31:0] rpc, input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt);
    res_valid       = 1'b1;
    res_pc          = rpc;
    res_taken       = tk;
    res_target      = tgt;
    res_pred_taken  = ptk;
    res_pred_target = ptgt;
  endtask

  task automatic do_eret(input logic [31:0] addr);
    eret_req = 1'b1;
    epc      = addr;
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; exc_req = 1'b0; eret_req = 1'b0; epc = 32'd0;
    res_valid = 1'b0; res_pc = 32'd0; res_taken = 1'b0; res_target = 32'd0;
    res_pred_taken = 1'b0; res_pred_target = 32'd0;

    // Reset held for two cycles, then sequential fetch.
    step("rst0", 32'h3000, 1'b0, 32'h0, 2'd0);
    step("rst1", 32'h3000, 1'b0, 32'h0, 2'd0);
    reset = 1'b1;
    step("run0", 32'h3004, 1'b0, 32'h0, 2'd0);
    step("run1", 32'h3008, 1'b0, 32'h0, 2'd0);

    // Cold taken branch: miss, allocate, redirect.
    resolve(32'h3008, 1'b1, 32'h3100, 1'b0, 32'h0);
    chk_flush("cold", 1'b1);
    step("cold", 32'h3100, 1'b0, 32'h0, 2'd1);

    // Refetch 0x3008: now predicted taken with delay slot.
    do_eret(32'h3008);
    step("back", 32'h3008, 1'b1, 32'h3100, 2'd1);
    step("dslot", 32'h300C, 1'b0, 32'h0, 2'd1);
    stall = 1'b1;
    step("stall0", 32'h300C, 1'b0, 32'h0, 2'd1);
    step("stall1", 32'h300C, 1'b0, 32'h0, 2'd1);
    stall = 1'b0;
    step("ptgt", 32'h3100, 1'b0, 32'h0, 2'd1);
    step("seq", 32'h3104, 1'b0, 32'h0, 2'd1);

    // Not-taken mispredict while the delay slot is pending.
    do_eret(32'h3008);
    step("back2", 32'h3008, 1'b1, 32'h3100, 2'd1);
    step("dslot2", 32'h300C, 1'b0, 32'h0, 2'd1);
    resolve(32'h3008, 1'b0, 32'h0, 1'b1, 32'h3100);
    chk_flush("ntmis", 1'b1);
    step("ntmis", 32'h3010, 1'b0, 32'h0, 2'd2);
    step("nopend", 32'h3014, 1'b0, 32'h0, 2'd2);
    do_eret(32'h3008);
    step("weak", 32'h3008, 1'b0, 32'h0, 2'd2);

    // Correctly predicted taken resolution: hit, ctr 1 -> 2, no flush.
    resolve(32'h3008, 1'b1, 32'h3100, 1'b1, 32'h3100);
    chk_flush("train", 1'b0);
    step("train", 32'h300C, 1'b0, 32'h0, 2'd2);
    do_eret(32'h3008);
    step("strong", 32'h3008, 1'b1, 32'h3100, 2'd2);
    step("dslot3", 32'h300C, 1'b0, 32'h0, 2'd2);

    // exc_req + eret_req + mispredict with pending set.
    exc_req = 1'b1;
    do_eret(32'h3020);
    resolve(32'h3040, 1'b1, 32'h3200, 1'b0, 32'h0);
    chk_flush("prio", 1'b0);
    step("prio", 32'h4180, 1'b0, 32'h0, 2'd3);
    step("nopend2", 32'h4184, 1'b0, 32'h0, 2'd3);
    do_eret(32'h3020);
    step("eret", 32'h3020, 1'b0, 32'h0, 2'd3);

    // Counter saturation (4th and 5th mispredicts), redirect beats stall.
    resolve(32'h3048, 1'b0, 32'h0, 1'b1, 32'h3100);
    chk_flush("sat4", 1'b1);
    step("sat4", 32'h3050, 1'b0, 32'h0, 2'd3);
    stall = 1'b1;
    resolve(32'h3060, 1'b0, 32'h0, 1'b1, 32'h3100);
    chk_flush("stallmis", 1'b1);
    step("stallmis", 32'h3068, 1'b0, 32'h0, 2'd3);
    stall = 1'b0;

    // Aliasing: same index as 0x3008, different tag -> miss.
    do_eret(32'h3048);
    step("alias", 32'h3048, 1'b0, 32'h0, 2'd3);
    do_eret(32'h3008);
    step("hit", 32'h3008, 1'b1, 32'h3100, 2'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
